adder_arbiter: RTL and testbench

- Shares the single 32-bit ripple adder (`adder`, no carry-in) between NUM_REQ requesters in the QOA decode datapath, e.g. LMS predictor accumulate, residual add and weight update.
- Round-robin arbitration with a valid/ready request handshake.
- Subtraction is sequenced as two adder passes: negate b, then add.
- Returns a registered sum and a signed-overflow flag with a one-hot response strobe.

---
 rtl/qoa_arith_pkg.sv | 27 ++
 rtl/adder.sv | 22 ++
 rtl/adder_arbiter_rr_grant.sv | 46 ++++
 rtl/adder_arbiter.sv | 147 ++++++++++++++
 tb/tb_adder_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/qoa_arith_pkg.sv
// Shared arithmetic definitions for the QOA decode datapath: operand width,
// adder-arbiter state encodings and a signed-overflow helper.
package qoa_arith_pkg;

    localparam int QOA_WIDTH = 32;

    localparam logic [QOA_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEG  = 2'd1,
        ST_SUM  = 2'd2
    } arb_state_e;

    // Two's-complement overflow of s = a + b: operands share a sign and the
    // result sign differs from it.
    function automatic logic add_ovf(
        input logic [QOA_WIDTH-1:0] a,
        input logic [QOA_WIDTH-1:0] b,
        input logic [QOA_WIDTH-1:0] s
    );
        logic ovf;
        ovf = (a[QOA_WIDTH-1] == b[QOA_WIDTH-1]) && (s[QOA_WIDTH-1] != a[QOA_WIDTH-1]);
        return ovf;
    endfunction

endpackage

// File: rtl/adder.sv
// Shared WIDTH-bit ripple-carry adder without carry-in or carry-out.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    logic carry_s;

    // Bit-serial ripple of the carry from LSB to MSB.
    always_comb begin
        sum_o   = '0;
        carry_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s;
            carry_s  = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// File: rtl/adder_arbiter_rr_grant.sv
// Round-robin grant search: first set request bit strictly after the pointer,
// wrapping around; purely combinational.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   pos_s;
    logic [IDX_W-1:0] cand_s;

    // Walk offsets 1..NUM_REQ from the pointer and keep the first requester hit.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        pos_s  = '0;
        cand_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos_s = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos_s >= (IDX_W+1)'(NUM_REQ)) begin
                pos_s = pos_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                pos_s = pos_s;
            end
            cand_s = pos_s[IDX_W-1:0];
            if (!any_o && req_i[cand_s]) begin
                any_o = 1'b1;
                idx_o = cand_s;
            end else begin
                any_o = any_o;
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one ripple adder between NUM_REQ requesters. Adds take one adder
// pass (SUM); subtracts take two (NEG computes -b, then SUM adds it to a).
module adder_arbiter
    import qoa_arith_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = QOA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_sub,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_ovf,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic                neg_ovf_q, neg_ovf_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_sum_q, rsp_sum_d;
    logic                rsp_ovf_q, rsp_ovf_d;

    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic                grant_any_s;
    logic [WIDTH-1:0]    add_a_s, add_b_s, add_sum_s;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .ptr_i (ptr_q),
        .req_i (req_valid),
        .gnt_o (grant_s),
        .idx_o (grant_idx_s),
        .any_o (grant_any_s)
    );

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i   (add_a_s),
        .b_i   (add_b_s),
        .sum_o (add_sum_s)
    );

    // Next-state, handshake and adder-operand selection.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        neg_ovf_d   = neg_ovf_q;
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovf_d   = rsp_ovf_q;
        req_ready   = '0;
        add_a_s     = '0;
        add_b_s     = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    req_ready = grant_s;
                    op_a_d    = req_a[grant_idx_s*WIDTH +: WIDTH];
                    op_b_d    = req_b[grant_idx_s*WIDTH +: WIDTH];
                    owner_d   = grant_idx_s;
                    ptr_d     = grant_idx_s;
                    neg_ovf_d = 1'b0;
                    if (req_sub[grant_idx_s]) begin
                        state_d = ST_NEG;
                    end else begin
                        state_d = ST_SUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NEG: begin
                // -b = ~b + 1; INT_MIN negates to itself, remembered for SUM.
                add_a_s   = ~op_b_q;
                add_b_s   = WIDTH'(1);
                op_b_d    = add_sum_s;
                neg_ovf_d = (op_b_q == INT_MIN);
                state_d   = ST_SUM;
            end
            ST_SUM: begin
                add_a_s              = op_a_q;
                add_b_s              = op_b_q;
                rsp_sum_d            = add_sum_s;
                rsp_valid_d[owner_q] = 1'b1;
                if (neg_ovf_q) begin
                    // a - INT_MIN overflows exactly when a is non-negative.
                    rsp_ovf_d = ~op_a_q[WIDTH-1];
                end else begin
                    rsp_ovf_d = add_ovf(op_a_q, op_b_q, add_sum_s);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDX_W'(NUM_REQ-1);
            owner_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            neg_ovf_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            neg_ovf_q   <= neg_ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: adds, subtracts, overflow corners,
// round-robin ordering, reset mid-operation and back-to-back accepts.
module tb_adder_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_sub;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_ovf;
    logic           busy;

    int vectors = 0;
    int errors  = 0;

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation from requester idx; ends in the response cycle.
    task automatic run_op(input string tag, input int idx, input logic sub,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum, input logic exp_ovf);
        logic [N-1:0] oh;
        oh = 4'b0001 << idx;
        req_valid          = '0;
        req_valid[idx]     = 1'b1;
        req_sub[idx]       = sub;
        req_a[idx*W +: W]  = a;
        req_b[idx*W +: W]  = b;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        if (sub) begin
            #1;
            chk({tag, "_neg_quiet"}, 32'(rsp_valid), 32'd0);
            tick();
        end
        #1;
        chk({tag, "_sum_quiet"}, 32'(rsp_valid), 32'd0);
        tick();
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
        chk({tag, "_rsp_sum"}, rsp_sum, exp_sum);
        chk({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
    endtask

    initial begin
        logic [N-1:0]  oh;
        logic [31:0]   rr_sum [N];
        rst       = 1'b1;
        req_valid = '0;
        req_sub   = '0;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_sum", rsp_sum, 32'd0);
        chk("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        tick();

        run_op("add_5_7", 0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0);
        tick();
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rsp_sum_hold", rsp_sum, 32'd12);
        run_op("sub_3_10", 2, 1'b1, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0);
        run_op("sub_0_min", 3, 1'b1, 32'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op("add_max_1", 0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
        run_op("add_min_m1", 1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);

        // Reset while a subtract sits in NEG.
        req_valid    = 4'b0010;
        req_sub      = 4'b0010;
        req_a[W +: W] = 32'd50;
        req_b[W +: W] = 32'd8;
        tick();
        req_valid = '0;
        #1;
        chk("rst_neg_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_neg_idle", 32'(busy), 32'd0);
        chk("rst_neg_sum", rsp_sum, 32'd0);
        tick();
        #1;
        chk("rst_neg_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        chk("rst_neg_no_rsp2", 32'(rsp_valid), 32'd0);

        // All four requesting continuously: grants 0,1,2,3,0 every 2 cycles.
        req_sub = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 32'h10 * (i + 1);
            req_b[i*W +: W] = i;
        end
        rr_sum[0] = 32'h10;
        rr_sum[1] = 32'h21;
        rr_sum[2] = 32'h32;
        rr_sum[3] = 32'h43;
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << (j % N);
            #1;
            chk("rr_ready", 32'(req_ready), 32'(oh));
            if (j > 0) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((j - 1) % N)));
                chk("rr_rsp_sum", rsp_sum, rr_sum[(j - 1) % N]);
            end
            tick();
            #1;
            chk("rr_sum_ready", 32'(req_ready), 32'd0);
            chk("rr_sum_quiet", 32'(rsp_valid), 32'd0);
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_last_valid", 32'(rsp_valid), 32'd1);
        chk("rr_last_sum", rsp_sum, 32'h10);
        tick();

        // Back-to-back adds from requester 1.
        req_valid     = 4'b0010;
        req_a[W +: W] = 32'd1000;
        req_b[W +: W] = 32'd234;
        #1;
        chk("b2b_ready1", 32'(req_ready), 32'b0010);
        tick();
        req_a[W +: W] = 32'hFFFF_FFFF;
        req_b[W +: W] = 32'hFFFF_FFFF;
        #1;
        chk("b2b_quiet1", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        chk("b2b_ready2", 32'(req_ready), 32'b0010);
        chk("b2b_rsp1_valid", 32'(rsp_valid), 32'b0010);
        chk("b2b_rsp1_sum", rsp_sum, 32'd1234);
        tick();
        req_valid = '0;
        #1;
        chk("b2b_quiet2", 32'(rsp_valid), 32'd0);
        chk("b2b_hold_sum", rsp_sum, 32'd1234);
        tick();
        #1;
        chk("b2b_rsp2_valid", 32'(rsp_valid), 32'b0010);
        chk("b2b_rsp2_sum", rsp_sum, 32'hFFFF_FFFE);
        chk("b2b_rsp2_ovf", 32'(rsp_ovf), 32'd0);
        tick();
        #1;
        chk("b2b_end_quiet", 32'(rsp_valid), 32'd0);
        chk("b2b_end_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
